// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
//   Shared constants for the 7-segment display blocks.
//   - NUM_DIGITS : number of scanned digits (fixed at 6: hh:mm:ss)
//   - SEG_*      : glyphs as active-high {g,f,e,d,c,b,a}, bit0 = a.
//                  Output polarity is applied by the consumer, not here.
//   - slot_phase_e : sub-phase of a digit slot (dead time / digit shown)
// ---------------------------------------------------------------------------
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 6;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  typedef enum logic {
    PH_DEAD = 1'b0,
    PH_SHOW = 1'b1
  } slot_phase_e;

endpackage

// File: rtl/seg7_scan_bcd_to_seg7.sv
// ---------------------------------------------------------------------------
// bcd_to_seg7
//   Combinational BCD nibble to 7-segment glyph (active-high {g..a}).
//   Codes 10-15 are not valid BCD and decode to a dash as an error marker.
//   Ports:
//     bcd_i  in  4  BCD digit
//     seg_o  out 7  glyph, bit0 = segment a
// ---------------------------------------------------------------------------
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    unique case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// ---------------------------------------------------------------------------
// seg7_scan
//   Time-multiplexes six BCD digits onto a 6-digit 7-segment display.
//   Each digit slot lasts DIGIT_TICKS cycles; the first DEAD_TICKS cycles of
//   a slot keep every select and segment off to avoid ghosting. The input
//   digits, blanking enable and dp mask are captured once per frame so a
//   carry ripple upstream never tears the displayed value.
//   Ports:
//     clk          in   1   system clock
//     rst          in   1   synchronous reset, active-high
//     en           in   1   1: scan, 0: display dark and scan held at digit 0
//     lzb          in   1   leading-zero blanking enable
//     digits_in    in   24  digit i at [4i+3:4i]; digit 0 = seconds units
//     dp_mask      in   6   bit i lights the decimal point of digit i
//     seg          out  7   segments {g..a}, polarity set by ACTIVE_LOW
//     dp           out  1   decimal point
//     sel          out  6   digit select, at most one bit active
//     frame_start  out  1   one-cycle pulse when the snapshot is taken
// ---------------------------------------------------------------------------
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned DIGIT_TICKS = 50000,
  parameter int unsigned DEAD_TICKS  = 500,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      lzb,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0]     dp_mask,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     sel,
  output logic                      frame_start
);

  localparam int unsigned TW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam int unsigned IW = $clog2(NUM_DIGITS);

  localparam logic [TW-1:0] TC_LAST  = TW'(DIGIT_TICKS - 1);
  localparam logic [TW-1:0] TC_DEAD  = TW'(DEAD_TICKS);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  // Inactive levels of the physical outputs.
  localparam logic [6:0]            SEG_INACT = ACTIVE_LOW ? '1 : '0;
  localparam logic                  DP_INACT  = ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] SEL_INACT = ACTIVE_LOW ? '1 : '0;

  // Counters and snapshot.
  logic [TW-1:0]             tcnt_q, tcnt_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0]   snap_q;
  logic                      lzb_q;
  logic [NUM_DIGITS-1:0]     dpm_q;

  // Output registers.
  logic [6:0]                seg_q, seg_d;
  logic                      dp_q, dp_d;
  logic [NUM_DIGITS-1:0]     sel_q, sel_d;
  logic                      fs_q;

  // Combinational helpers.
  logic                      frame_go;
  logic [4*NUM_DIGITS-1:0]   snap_eff;
  logic                      lzb_eff;
  logic [NUM_DIGITS-1:0]     dpm_eff;
  logic [NUM_DIGITS-1:0]     blank;
  slot_phase_e               phase;
  logic [3:0]                nib;
  logic [6:0]                glyph;
  logic                      lit;
  logic [6:0]                seg_act;
  logic                      dp_act;
  logic [NUM_DIGITS-1:0]     sel_act;

  // (tcnt, idx) = (0, 0) with en high only occurs on the first cycle of a
  // frame: after reset, after en returns, or after the 5->0 wrap.
  assign frame_go = (tcnt_q == '0) && (idx_q == '0);

  // On the frame-start cycle the decode already uses the values being
  // captured, so the very first slot never shows the previous frame's data
  // even when DEAD_TICKS is zero.
  assign snap_eff = frame_go ? digits_in : snap_q;
  assign lzb_eff  = frame_go ? lzb       : lzb_q;
  assign dpm_eff  = frame_go ? dp_mask   : dpm_q;

  // Leading-zero mask: a digit is blank when it and every higher digit are
  // zero. Digit 0 is always shown.
  always_comb begin
    logic run;
    blank = '0;
    run   = lzb_eff;
    for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
      run      = run && (snap_eff[4*i +: 4] == 4'd0);
      blank[i] = run;
    end
  end

  assign phase = (tcnt_q < TC_DEAD) ? PH_DEAD : PH_SHOW;
  assign nib   = snap_eff[{idx_q, 2'b00} +: 4];

  bcd_to_seg7 u_dec (
    .bcd_i (nib),
    .seg_o (glyph)
  );

  always_comb begin
    lit     = (phase == PH_SHOW) && !blank[idx_q];
    seg_act = lit ? glyph : SEG_OFF;
    dp_act  = lit && dpm_eff[idx_q];
    sel_act = lit ? (NUM_DIGITS'(1) << idx_q) : '0;

    seg_d = ACTIVE_LOW ? ~seg_act : seg_act;
    dp_d  = ACTIVE_LOW ? ~dp_act  : dp_act;
    sel_d = ACTIVE_LOW ? ~sel_act : sel_act;
  end

  always_comb begin
    tcnt_d = tcnt_q + 1'b1;
    idx_d  = idx_q;
    if (tcnt_q == TC_LAST) begin
      tcnt_d = '0;
      idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q <= '0;
      idx_q  <= '0;
      snap_q <= '0;
      lzb_q  <= 1'b0;
      dpm_q  <= '0;
      seg_q  <= SEG_INACT;
      dp_q   <= DP_INACT;
      sel_q  <= SEL_INACT;
      fs_q   <= 1'b0;
    end else if (!en) begin
      // Hold at the start of digit 0 so en rising begins a fresh frame.
      tcnt_q <= '0;
      idx_q  <= '0;
      seg_q  <= SEG_INACT;
      dp_q   <= DP_INACT;
      sel_q  <= SEL_INACT;
      fs_q   <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      idx_q  <= idx_d;
      if (frame_go) begin
        snap_q <= digits_in;
        lzb_q  <= lzb;
        dpm_q  <= dp_mask;
      end
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      sel_q  <= sel_d;
      fs_q   <= frame_go;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign sel         = sel_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan
//   Self-checking bench for seg7_scan (DIGIT_TICKS=8, DEAD_TICKS=2,
//   ACTIVE_LOW=1). A frame-position reference model predicts every cycle;
//   a vector table and directed sequences pin down the documented cases.
// ---------------------------------------------------------------------------
module tb_seg7_scan;

  localparam int DT    = 8;
  localparam int DEAD  = 2;
  localparam int ND    = 6;
  localparam int FRAME = ND * DT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic        lzb = 1'b0;
  logic [23:0] digits_in = 24'h123456;
  logic [5:0]  dp_mask = 6'h00;
  logic [6:0]  seg;
  logic        dp;
  logic [5:0]  sel;
  logic        frame_start;

  seg7_scan #(
    .DIGIT_TICKS (DT),
    .DEAD_TICKS  (DEAD),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .lzb         (lzb),
    .digits_in   (digits_in),
    .dp_mask     (dp_mask),
    .seg         (seg),
    .dp          (dp),
    .sel         (sel),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Standard active-high glyphs, 10..15 shown as a dash.
  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  // Reference model: position within the frame plus the captured frame data.
  int         m_pos = 0;
  logic [3:0] m_dig [ND];
  logic       m_lzb = 1'b0;
  logic [5:0] m_dpm = '0;
  logic [5:0] e_sel;
  logic [6:0] e_seg;
  logic       e_dp;
  logic       e_fs;

  task automatic set_dark();
    e_sel = 6'h3F;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
  endtask

  task automatic model_step();
    int  slot;
    int  off;
    bit  lead;
    bit  blanked;
    if (rst) begin
      m_pos = 0;
      for (int i = 0; i < ND; i++) m_dig[i] = 4'd0;
      m_lzb = 1'b0;
      m_dpm = '0;
      set_dark();
      e_fs = 1'b0;
    end else if (!en) begin
      m_pos = 0;
      set_dark();
      e_fs = 1'b0;
    end else begin
      e_fs = (m_pos == 0);
      if (e_fs) begin
        for (int i = 0; i < ND; i++) m_dig[i] = digits_in[4*i +: 4];
        m_lzb = lzb;
        m_dpm = dp_mask;
      end
      slot = m_pos / DT;
      off  = m_pos % DT;
      lead = 1'b1;
      for (int k = slot; k < ND; k++) if (m_dig[k] != 4'd0) lead = 1'b0;
      blanked = m_lzb && (slot != 0) && lead;
      if (off < DEAD || blanked) begin
        set_dark();
      end else begin
        e_sel = ~(6'd1 << slot);
        e_seg = ~glyph[m_dig[slot]];
        e_dp  = ~m_dpm[slot];
      end
      m_pos = (m_pos + 1) % FRAME;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // One clock: model follows the edge, DUT sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model {sel,seg,dp,fs}", {17'd0, sel, seg, dp, frame_start},
          {17'd0, e_sel, e_seg, e_dp, e_fs});
    check("sel_onehot", 32'($countones(~sel) <= 1), 32'd1);
  endtask

  typedef struct {
    bit          lzb;
    logic [23:0] digits;
    logic [5:0]  dpm;
    int          slot;
    int          off;
    logic [5:0]  sel;
    logic [6:0]  seg;
    bit          dp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int cnt;
    logic [23:0] d;
    int k;

    vecs.push_back('{1'b0, 24'h123456, 6'h00, 0, 4, 6'h3E, 7'h02, 1'b1});
    vecs.push_back('{1'b0, 24'h123456, 6'h00, 5, 2, 6'h1F, 7'h79, 1'b1});
    vecs.push_back('{1'b0, 24'h123456, 6'h00, 3, 7, 6'h37, 7'h30, 1'b1});
    vecs.push_back('{1'b0, 24'h123456, 6'h00, 2, 1, 6'h3F, 7'h7F, 1'b1});
    vecs.push_back('{1'b1, 24'h000105, 6'h00, 5, 4, 6'h3F, 7'h7F, 1'b1});
    vecs.push_back('{1'b1, 24'h000105, 6'h00, 3, 4, 6'h3F, 7'h7F, 1'b1});
    vecs.push_back('{1'b1, 24'h000105, 6'h00, 2, 4, 6'h3B, 7'h79, 1'b1});
    vecs.push_back('{1'b1, 24'h000105, 6'h00, 1, 4, 6'h3D, 7'h40, 1'b1});
    vecs.push_back('{1'b1, 24'h000105, 6'h00, 0, 4, 6'h3E, 7'h12, 1'b1});
    vecs.push_back('{1'b1, 24'h000000, 6'h00, 0, 4, 6'h3E, 7'h40, 1'b1});
    vecs.push_back('{1'b1, 24'h000000, 6'h00, 1, 4, 6'h3F, 7'h7F, 1'b1});
    vecs.push_back('{1'b0, 24'h00000A, 6'h14, 0, 4, 6'h3E, 7'h3F, 1'b1});
    vecs.push_back('{1'b0, 24'h00000A, 6'h14, 2, 4, 6'h3B, 7'h40, 1'b0});
    vecs.push_back('{1'b0, 24'h00000A, 6'h14, 3, 4, 6'h37, 7'h40, 1'b1});
    vecs.push_back('{1'b0, 24'h00000A, 6'h14, 4, 4, 6'h2F, 7'h40, 1'b0});

    // Reset state and first frame pulse.
    repeat (3) tick();
    check("rst_sel", 32'(sel), 32'h3F);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp",  32'(dp), 32'd1);
    check("rst_fs",  32'(frame_start), 32'd0);
    rst = 1'b0;
    tick();
    check("fs_after_rst", 32'(frame_start), 32'd1);
    cnt = 0;
    repeat (FRAME - 1) begin
      tick();
      cnt += int'(frame_start);
    end
    check("fs_gap", 32'(cnt), 32'd0);
    tick();
    check("fs_period", 32'(frame_start), 32'd1);

    // Snapshot holds when digits change at idx=2.
    repeat (16) tick();
    digits_in = 24'h999999;
    repeat (20) tick();
    check("snap_hold_sel", 32'(sel), 32'h2F);
    check("snap_hold_seg", 32'(seg), 32'h24);
    repeat (FRAME) tick();
    check("snap_next_seg", 32'(seg), 32'h10);

    // Reset mid-slot at idx=3, tcnt=5.
    repeat (40) tick();
    rst = 1'b1;
    tick();
    check("midrst_sel", 32'(sel), 32'h3F);
    check("midrst_seg", 32'(seg), 32'h7F);
    check("midrst_dp",  32'(dp), 32'd1);
    rst = 1'b0;
    tick();
    check("midrst_fs", 32'(frame_start), 32'd1);

    // en low: dark, no frame pulse; en high: fresh frame.
    repeat (5) tick();
    en = 1'b0;
    cnt = 0;
    repeat (10) begin
      tick();
      cnt += int'(frame_start);
      check("en0_sel", 32'(sel), 32'h3F);
    end
    check("en0_nofs", 32'(cnt), 32'd0);
    en = 1'b1;
    tick();
    check("en1_fs", 32'(frame_start), 32'd1);
    repeat (4) tick();
    check("en1_sel", 32'(sel), 32'h3E);
    check("en1_seg", 32'(seg), 32'h10);

    // Table of single-slot observations, each in a fresh frame.
    foreach (vecs[v]) begin
      en = 1'b0;
      tick();
      lzb       = vecs[v].lzb;
      digits_in = vecs[v].digits;
      dp_mask   = vecs[v].dpm;
      en        = 1'b1;
      repeat (vecs[v].slot * DT + vecs[v].off + 1) tick();
      check($sformatf("vec%0d_sel", v), 32'(sel), 32'(vecs[v].sel));
      check($sformatf("vec%0d_seg", v), 32'(seg), 32'(vecs[v].seg));
      check($sformatf("vec%0d_dp", v),  32'(dp),  32'(vecs[v].dp));
    end

    // Randomized traffic against the model.
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < ND; i++) begin
        k = int'($urandom_range(0, 15));
        if (k > 9 && $urandom_range(0, 3) != 0) k = k % 10;
        d[4*i +: 4] = 4'(k);
      end
      k = int'($urandom_range(0, 6));
      for (int i = 0; i < ND; i++) if (i >= ND - k) d[4*i +: 4] = 4'd0;
      digits_in = d;
      lzb       = 1'($urandom_range(0, 1));
      dp_mask   = 6'($urandom_range(0, 63));
      case ($urandom_range(0, 9))
        0:       rst = 1'b1;
        1, 2:    en  = 1'b0;
        default: begin rst = 1'b0; en = 1'b1; end
      endcase
      repeat ($urandom_range(1, 3)) tick();
      rst = 1'b0;
      en  = 1'b1;
      repeat ($urandom_range(1, 100)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
